// File: rtl/setpoint_ramp_cfg.sv
// rtl/setpoint_ramp_cfg.sv - setpoint command decode with per-axis slew-limited ramp
// Optional SETTLE_ACK_EN: posack for channel writes is delayed until the written channel(s) settle.
module setpoint_ramp_cfg #(
    parameter int           NUM_CH   = 3,
    parameter int           DW       = 16,
    parameter logic [DW-1:0] STEP    = 16'h0010,
    parameter int           TICK_DIV = 1024,
    parameter logic [7:0]   CMD_BASE = 8'h02,
    parameter logic [7:0]   CMD_ZERO = 8'h0F
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_rdy,
    input  logic [7:0]           cmd,
    input  logic [DW-1:0]        data,
    output logic                 clr_cmd_rdy,
    output logic                 send_resp,
    output logic [7:0]           resp,
    output logic [NUM_CH*DW-1:0] tgt,
    output logic [NUM_CH*DW-1:0] d_sp,
    output logic [NUM_CH-1:0]    settled
);

    localparam logic [7:0]    RESP_ACK  = 8'hA5;
    localparam logic [7:0]    RESP_NACK = 8'hEE;
    localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ACK    = 2'd2
`ifdef SETTLE_ACK_EN
        , ST_WAIT = 2'd3
`endif
    } state_t;

    state_t          state;
    logic [DW-1:0]   tgt_r  [NUM_CH];
    logic [DW-1:0]   d_sp_r [NUM_CH];
    logic [CW-1:0]   tick_cnt;
    logic            tick;
    logic [NUM_CH-1:0] sel_mask;
    logic            is_zero;
    logic            cmd_valid;
`ifdef SETTLE_ACK_EN
    logic [NUM_CH-1:0] wait_mask;
`endif

    assign tick = (tick_cnt == TICK_LAST);

    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cmd == CMD_BASE + 8'(i)) sel_mask[i] = 1'b1;
        end
        is_zero   = (cmd == CMD_ZERO);
        cmd_valid = is_zero | (|sel_mask);
    end

    // Difference is taken one bit wider so full-scale swings (0x7FFF <-> 0x8000) cannot wrap.
    function automatic logic [DW-1:0] ramp_next(input logic [DW-1:0] cur, input logic [DW-1:0] goal);
        logic [DW:0]   diff;
        logic [DW:0]   mag;
        logic [DW-1:0] nxt;
        diff = {goal[DW-1], goal} - {cur[DW-1], cur};
        mag  = diff[DW] ? (~diff + 1'b1) : diff;
        if (mag <= {1'b0, STEP})
            nxt = goal;
        else if (diff[DW])
            nxt = cur - STEP;
        else
            nxt = cur + STEP;
        return nxt;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            settled  <= '1;
            for (int i = 0; i < NUM_CH; i++) d_sp_r[i] <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (tick) d_sp_r[i] <= ramp_next(d_sp_r[i], tgt_r[i]);
                settled[i] <= (d_sp_r[i] == tgt_r[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            clr_cmd_rdy <= 1'b0;
            send_resp   <= 1'b0;
            resp        <= 8'h00;
            for (int i = 0; i < NUM_CH; i++) tgt_r[i] <= '0;
`ifdef SETTLE_ACK_EN
            wait_mask   <= '0;
`endif
        end else begin
            clr_cmd_rdy <= 1'b0;
            send_resp   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_rdy) begin
                        state       <= ST_DECODE;
                        clr_cmd_rdy <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    state <= ST_ACK;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (is_zero)
                            tgt_r[i] <= '0;
                        else if (sel_mask[i])
                            tgt_r[i] <= data;
                    end
`ifdef SETTLE_ACK_EN
                    if (cmd_valid) begin
                        wait_mask <= is_zero ? {NUM_CH{1'b1}} : sel_mask;
                    end else begin
                        send_resp <= 1'b1;
                        resp      <= RESP_NACK;
                    end
`else
                    send_resp <= 1'b1;
                    resp      <= cmd_valid ? RESP_ACK : RESP_NACK;
`endif
                end
                ST_ACK: begin
`ifdef SETTLE_ACK_EN
                    state <= (|wait_mask) ? ST_WAIT : ST_IDLE;
`else
                    state <= ST_IDLE;
`endif
                end
`ifdef SETTLE_ACK_EN
                // settled is already one cycle behind tgt, so it is valid from the first WAIT cycle.
                ST_WAIT: begin
                    if ((settled & wait_mask) == wait_mask) begin
                        send_resp <= 1'b1;
                        resp      <= RESP_ACK;
                        wait_mask <= '0;
                        state     <= ST_ACK;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign tgt[g*DW +: DW]  = tgt_r[g];
        assign d_sp[g*DW +: DW] = d_sp_r[g];
    end

endmodule

// File: tb/tb_setpoint_ramp_cfg.sv
// tb/tb_setpoint_ramp_cfg.sv - scoreboard bench for setpoint_ramp_cfg
module tb_setpoint_ramp_cfg;

    localparam int          NC = 3;
    localparam int          W  = 16;
    localparam int          TD = 4;
    localparam logic [15:0] ST = 16'h0010;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_rdy = 1'b0;
    logic [7:0]    cmd = 8'h00;
    logic [15:0]   data = 16'h0000;
    logic          clr_cmd_rdy;
    logic          send_resp;
    logic [7:0]    resp;
    logic [NC*W-1:0] tgt;
    logic [NC*W-1:0] d_sp;
    logic [NC-1:0] settled;

    int         total = 0;
    int         bad = 0;
    logic [7:0] resp_q[$];
    logic [7:0] exp_resp_r;

    always #5 clk = ~clk;

    setpoint_ramp_cfg #(
        .NUM_CH(NC), .DW(W), .STEP(ST), .TICK_DIV(TD),
        .CMD_BASE(8'h02), .CMD_ZERO(8'h0F)
    ) dut (
        .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
        .tgt(tgt), .d_sp(d_sp), .settled(settled)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sp(input int ch);
        return d_sp[ch*W +: W];
    endfunction

    always @(negedge clk) begin
        if (send_resp) begin
            if (resp_q.size() == 0) begin
                check("resp_unexpected", 64'd1, 64'd0);
            end else begin
                exp_resp_r = resp_q.pop_front();
                check("resp", resp, exp_resp_r);
            end
        end
    end

    task automatic wait_resp(input int lim);
        int n = 0;
        while (resp_q.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("resp_timeout", resp_q.size(), 0);
        resp_q.delete();
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [15:0] val, input logic [7:0] exp_resp);
        int n = 0;
        bit slow = 1'b0;
`ifdef SETTLE_ACK_EN
        if (exp_resp == 8'hA5) slow = 1'b1;
`endif
        @(negedge clk);
        resp_q.push_back(exp_resp);
        cmd = op;
        data = val;
        cmd_rdy = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!clr_cmd_rdy && n < 8);
        check("clr_latency", n, 1);
        cmd_rdy = 1'b0;
        if (!slow) begin
            @(negedge clk);
            check("resp_latency", send_resp, 1);
        end
        wait_resp(40000);
    endtask

    task automatic wait_sp(input int ch, input logic [15:0] v, input int lim);
        int n = 0;
        while (sp(ch) != v && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("sp_reach", sp(ch), v);
    endtask

    // Follows one channel until it reaches target, flagging any step that is not a clean slew step.
    task automatic ramp_watch(input int ch, input logic [15:0] target, input int lim, output int ticks);
        logic [15:0] prev;
        logic [15:0] cur;
        int viol = 0;
        int n = 0;
        int step;
        int dirv;
        ticks = 0;
        prev = sp(ch);
        dirv = ($signed(target) > $signed(prev)) ? 1 : -1;
        while (prev != target && n < lim) begin
            @(negedge clk);
            n++;
            cur = sp(ch);
            if (cur != prev) begin
                ticks++;
                step = dirv * (int'($signed(cur)) - int'($signed(prev)));
                if (step <= 0 || step > int'(ST) || (step < int'(ST) && cur != target)) viol++;
                prev = cur;
            end
        end
        check("ramp_end", prev, target);
        check("ramp_viol", viol, 0);
    endtask

    task automatic settle_ack_watch(input int ch, input int lim);
        logic prev;
        int n = 0;
        bit seen = 1'b0;
        prev = settled[ch];
        while (!seen && n < lim) begin
            @(negedge clk);
            n++;
            if (!prev && settled[ch]) begin
                seen = 1'b1;
                @(negedge clk);
                check("ack_after_settle", send_resp, 1);
            end
            prev = settled[ch];
        end
        check("settle_seen", seen, 1);
    endtask

    initial begin
        int ticks;
        int unsettled;
        int stray;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tgt", tgt, 0);
        check("rst_dsp", d_sp, 0);
        check("rst_settled", settled, 3'b111);
        check("rst_send_resp", send_resp, 0);
        check("rst_clr", clr_cmd_rdy, 0);
        check("rst_resp", resp, 8'h00);
        rst = 1'b0;

        send_cmd(8'h02, 16'h0001, 8'hA5);
        check("tgt0_one", tgt[15:0], 16'h0001);
        wait_sp(0, 16'h0001, 3*TD);
        repeat (2) @(negedge clk);
        check("settled0", settled[0], 1);

        send_cmd(8'h02, 16'h0000, 8'hA5);
        wait_sp(0, 16'h0000, 3*TD);
        fork
            send_cmd(8'h02, 16'h0800, 8'hA5);
            ramp_watch(0, 16'h0800, 128*TD + 100, ticks);
        join
        check("ramp_up_ticks", ticks, 128);

        send_cmd(8'h03, 16'h7FF8, 8'hA5);
        wait_sp(1, 16'h7FF8, 2100*TD);
        fork
            send_cmd(8'h03, 16'h8000, 8'hA5);
            ramp_watch(1, 16'h8000, 4200*TD, ticks);
        join
        check("ramp_down_ticks", ticks, 4096);

        send_cmd(8'h55, 16'h1234, 8'hEE);
        check("nack_tgt_held", tgt, {16'h0000, 16'h8000, 16'h0800});

        send_cmd(8'h04, 16'h0000, 8'hA5);
        unsettled = 0;
        repeat (3*TD) begin
            @(negedge clk);
            if (!settled[2]) unsettled++;
        end
        check("equal_write_settled", unsettled, 0);

        send_cmd(8'h0F, 16'h5555, 8'hA5);
        check("zero_tgt", tgt, 0);
        wait_sp(1, 16'h0000, 2100*TD);
        wait_sp(0, 16'h0000, 200*TD);

        @(negedge clk);
        cmd = 8'h04;
        data = 16'h1234;
        cmd_rdy = 1'b1;
        @(negedge clk);
        check("rst_dec_clr", clr_cmd_rdy, 1);
        rst = 1'b1;
        cmd_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (send_resp) stray++;
        end
        check("rst_dec_no_resp", stray, 0);
        check("rst_dec_tgt2", tgt[47:32], 16'h0000);

        fork
            send_cmd(8'h04, 16'h0040, 8'hA5);
            ramp_watch(2, 16'h0040, 8*TD + 20, ticks);
`ifdef SETTLE_ACK_EN
            settle_ack_watch(2, 8*TD + 20);
`endif
        join
        check("ramp_ch2_ticks", ticks, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
